scm_fifo_ctrl: RTL and testbench
================================

Name: scm_fifo_ctrl

Overview:
Valid/ready FIFO built on the team's 1R/1W SCM register file, which has a one-cycle registered read. Generates write/read addresses and occupancy, and hides the read latency behind a 2-entry output buffer, so it sustains one word per cycle in and out. Sits upstream of the storage macro and feeds it; serves as the standard buffered queue for stream datapaths.

Parameters:
ADDR_WIDTH, 5, log2 of storage depth; DEPTH = 2**ADDR_WIDTH words.
DATA_WIDTH, 32, word width.
BLOCK_RAM, 1, passed to the storage (1 = BRAM-style, 0 = flop array).

Ports:
clk  in  1  clock.
rst  in  1  synchronous, active-high reset.
flush_i  in  1  synchronous clear of all contents.
in_valid_i  in  1  producer word valid.
in_ready_o  out  1  space in storage.
in_data_i  in  DATA_WIDTH  producer word.
out_valid_o  out  1  output buffer head valid.
out_ready_i  in  1  consumer accepts.
out_data_o  out  DATA_WIDTH  output buffer head word.
level_o  out  ADDR_WIDTH+2  total words held (storage + in-flight + buffer).

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, rst. Storage rst_n is tied to ~rst.
- Reset or flush_i (rst has priority; identical effect): wr_ptr, rd_ptr and st_cnt go to 0, rd_inflight to 0, buffer emptied. Outputs: in_ready_o=1, out_valid_o=0, out_data_o=0, level_o=0. Any read returning in the next cycle is discarded. A push in the flush cycle is dropped.
- Push: when in_valid_i&in_ready_o, write in_data_i at wr_ptr. wr_ptr increments modulo DEPTH; st_cnt increments.
- in_ready_o = (st_cnt < DEPTH), taken from registered state only. A read issued in the same cycle does not raise in_ready_o until the next cycle, so there is no combinational ready path.
- Read issue: rd_en=1 when st_cnt>0 and (buf_occ + rd_inflight − pop) < 2, where pop = out_valid_o&out_ready_i. On issue, rd_ptr increments modulo DEPTH, st_cnt decrements, and rd_inflight is set for one cycle.
- A word written at edge N is first readable in cycle N+1; st_cnt is registered, so a word is never read in the cycle it is written. No read-during-write hazard arises.
- Return: in the cycle after rd_en, storage ReadData is written into the buffer tail at the clock edge.
- Buffer: 2-entry register FIFO. The head drives out_data_o; out_valid_o = buf_occ>0. On pop the head advances.
- Buffer same-cycle rules:
  - Simultaneous return and pop with buf_occ=1: the returned word becomes the head.
  - Simultaneous return and pop with buf_occ=0: not possible, since out_valid_o=0.
  - buf_occ never exceeds 2; this is guaranteed by the credit rule.
- out_data_o holds its value while out_valid_o&~out_ready_i (AXI-style stability). out_valid_o never drops without a pop.
- Latency on an empty FIFO: push in cycle 0, read issue in cycle 1, data returns in cycle 2, out_valid_o in cycle 3.
- Steady state with out_ready_i=1: 1 word/cycle throughput.
- Capacity: DEPTH words accepted while the output is stalled, plus up to 2 drained into the buffer. Maximum level_o = DEPTH+2.
- Counter arithmetic:
  - st_cnt is ADDR_WIDTH+1 bits.
  - Pointers are ADDR_WIDTH bits with natural wrap.
  - level_o = st_cnt + rd_inflight + buf_occ, registered.
- Simultaneous push and read issue with st_cnt=DEPTH cannot occur, because in_ready_o=0.

Decomposition:
- Package scm_fifo_pkg holds:
  - buf_occ typedef (2-bit).
  - Function computing level width from ADDR_WIDTH.
- One sub-module, scm_fifo_outbuf: 2-entry valid/ready register buffer with push/pop/occupancy.
- Storage is the existing 1R/1W register file, instantiated with ADDR_WIDTH, DATA_WIDTH and BLOCK_RAM passed through.

Test Plan:
- Single word, ADDR_WIDTH=2: push 0xA5A5_0001 in cycle 0 with out_ready_i=1 -> out_valid_o=1 in cycle 3 with out_data_o=0xA5A5_0001; level_o goes 0,1,1,1,0.
- Fill while stalled (out_ready_i=0): push 0..9 -> accepts 6 words (4 storage + 2 buffer); in_ready_o=0 once level_o=6; out_data_o holds 0 throughout.
- Drain after fill: out_ready_i=1 -> words 0..5 are popped on consecutive cycles with no bubbles; in_ready_o returns to 1 the cycle after the first read issue.
- Streaming: continuous push of 0..99 with out_ready_i=1 -> output 0..99 in order, 1/cycle after the 3-cycle fill, pointers wrap 25 times; random out_ready_i toggling -> same order, no loss.
- Flush: flush_i during a read-in-flight cycle with level_o=5 -> next cycle level_o=0 and out_valid_o=0, the returned word is not delivered, and a subsequent push of 0x77 emerges alone.
- Reset mid-stream: rst for 1 cycle while out_valid_o=1 -> all outputs at reset values next cycle; repeat both single-word and streaming tests with BLOCK_RAM=0.

Source files
------------

// File: rtl/scm_fifo_pkg.sv
// Shared types and helpers for the SCM-backed valid/ready FIFO controller.
package scm_fifo_pkg;

    typedef logic [1:0] buf_occ_t;

    // level_o must represent DEPTH + 2, hence two bits beyond the address.
    function automatic int level_width(input int addr_width);
        return addr_width + 2;
    endfunction

endpackage

// File: rtl/scm_fifo_outbuf.sv
// Two-entry register buffer that absorbs the storage read latency.
module scm_fifo_outbuf
    import scm_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output buf_occ_t              occ
);

    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] tail;
    buf_occ_t              occ_q;

    // The credit rule upstream keeps push from arriving when full.
    always_ff @(posedge clk) begin
        if (clear) begin
            occ_q <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        head <= push_data;
                    end else begin
                        tail <= push_data;
                    end
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    occ_q <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd2) begin
                        head <= tail;
                        tail <= push_data;
                    end else begin
                        head <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign valid = (occ_q != 2'd0);
    assign data  = head;
    assign occ   = occ_q;

endmodule

// File: rtl/scm_rf_1r1w.sv
// 1R/1W SCM register file with a registered read port (one-cycle read latency).
module scm_rf_1r1w #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_RAM  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    generate
        if (BLOCK_RAM != 0) begin : g_bram
            // No reset on the array so it maps onto block RAM.
            always_ff @(posedge clk) begin
                if (we) begin
                    mem[waddr] <= wdata;
                end
            end
        end else begin : g_flop
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    mem <= '{default: '0};
                end else if (we) begin
                    mem[waddr] <= wdata;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/scm_fifo_ctrl.sv
// Valid/ready FIFO over the 1R/1W SCM register file; a 2-entry output buffer
// hides the registered read so the queue sustains one word per cycle.
module scm_fifo_ctrl
    import scm_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_RAM  = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush_i,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    input  logic [DATA_WIDTH-1:0]              in_data_i,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [DATA_WIDTH-1:0]              out_data_o,
    output logic [level_width(ADDR_WIDTH)-1:0] level_o
);

    localparam int                DEPTH     = 2 ** ADDR_WIDTH;
    localparam int                LVL_W     = level_width(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   st_cnt;
    logic                  rd_inflight;
    logic [LVL_W-1:0]      level;
    logic                  clear;
    logic                  push;
    logic                  pop;
    logic                  rd_en;
    logic [2:0]            credit;
    buf_occ_t              buf_occ;
    logic [DATA_WIDTH-1:0] rd_data;

    assign clear      = rst | flush_i;
    assign in_ready_o = (st_cnt < DEPTH_CNT);
    assign push       = in_valid_i & in_ready_o & ~clear;
    assign pop        = out_valid_o & out_ready_i;

    // Buffer slots already spoken for after this cycle's pop; never over-issue.
    assign credit = {1'b0, buf_occ} + {2'b00, rd_inflight} - {2'b00, pop};
    assign rd_en  = (st_cnt != '0) && (credit < 3'd2) && !clear;

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            st_cnt      <= '0;
            rd_inflight <= 1'b0;
            level       <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            rd_inflight <= rd_en;

            unique case ({push, rd_en})
                2'b10:   st_cnt <= st_cnt + (ADDR_WIDTH + 1)'(1);
                2'b01:   st_cnt <= st_cnt - (ADDR_WIDTH + 1)'(1);
                default: st_cnt <= st_cnt;
            endcase

            // Words only enter at push and leave at pop; reads just move them.
            unique case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    assign level_o = level;

    scm_rf_1r1w #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .BLOCK_RAM (BLOCK_RAM)
    ) u_storage (
        .clk  (clk),
        .rst_n(~rst),
        .we   (push),
        .waddr(wr_ptr),
        .wdata(in_data_i),
        .re   (rd_en),
        .raddr(rd_ptr),
        .rdata(rd_data)
    );

    // A return landing in a flush cycle is dropped by the buffer clear.
    scm_fifo_outbuf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_outbuf (
        .clk      (clk),
        .clear    (clear),
        .push     (rd_inflight),
        .push_data(rd_data),
        .pop      (pop),
        .valid    (out_valid_o),
        .data     (out_data_o),
        .occ      (buf_occ)
    );

endmodule

// File: tb/tb_scm_fifo_ctrl.sv
// Directed table-driven bench for scm_fifo_ctrl, run on a BRAM and a flop-array instance.
module tb_scm_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst      [2];
    logic        flush    [2];
    logic        in_valid [2];
    logic        in_ready [2];
    logic [31:0] in_data  [2];
    logic        out_valid[2];
    logic        out_ready[2];
    logic [31:0] out_data [2];
    logic [3:0]  level    [2];

    int n_checks = 0;
    int n_err    = 0;
    int cur_u    = 0;

    always #5 clk = ~clk;

    scm_fifo_ctrl #(.ADDR_WIDTH(2), .DATA_WIDTH(32), .BLOCK_RAM(1)) u_bram (
        .clk(clk), .rst(rst[0]), .flush_i(flush[0]),
        .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]), .in_data_i(in_data[0]),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]), .out_data_o(out_data[0]),
        .level_o(level[0])
    );

    scm_fifo_ctrl #(.ADDR_WIDTH(2), .DATA_WIDTH(32), .BLOCK_RAM(0)) u_flop (
        .clk(clk), .rst(rst[1]), .flush_i(flush[1]),
        .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]), .in_data_i(in_data[1]),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]), .out_data_o(out_data[1]),
        .level_o(level[1])
    );

    typedef struct {
        logic        r;
        logic        f;
        logic        iv;
        logic [31:0] id;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic        chk_od;
        logic [31:0] e_od;
        logic [3:0]  e_lvl;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic f, input logic iv,
                                input logic [31:0] id, input logic ordy,
                                input logic e_ir, input logic e_ov, input logic chk_od,
                                input logic [31:0] e_od, input logic [3:0] e_lvl);
        vec_t t;
        t.r = r; t.f = f; t.iv = iv; t.id = id; t.ordy = ordy;
        t.e_ir = e_ir; t.e_ov = e_ov; t.chk_od = chk_od; t.e_od = e_od; t.e_lvl = e_lvl;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (inst %0d, t=%0t): got %h expected %h", name, cur_u, $time, act, exp);
        end
    endtask

    task automatic build_table();
        // Reset state, then a single word through an empty FIFO.
        vecs.push_back(mk(0,0,0,32'h0,1,         1,0,1,32'h0,4'd0));
        vecs.push_back(mk(0,0,1,32'hA5A5_0001,1, 1,0,0,32'h0,4'd0));
        vecs.push_back(mk(0,0,0,32'h0,1,         1,0,0,32'h0,4'd1));
        vecs.push_back(mk(0,0,0,32'h0,1,         1,0,0,32'h0,4'd1));
        vecs.push_back(mk(0,0,0,32'h0,1,         1,1,1,32'hA5A5_0001,4'd1));
        vecs.push_back(mk(0,0,0,32'h0,1,         1,0,0,32'h0,4'd0));
        // Fill while stalled: pushes 0..9, only 0..5 accepted.
        vecs.push_back(mk(0,0,1,32'd0,0, 1,0,0,32'h0,4'd0));
        vecs.push_back(mk(0,0,1,32'd1,0, 1,0,0,32'h0,4'd1));
        vecs.push_back(mk(0,0,1,32'd2,0, 1,0,0,32'h0,4'd2));
        vecs.push_back(mk(0,0,1,32'd3,0, 1,1,1,32'h0,4'd3));
        vecs.push_back(mk(0,0,1,32'd4,0, 1,1,1,32'h0,4'd4));
        vecs.push_back(mk(0,0,1,32'd5,0, 1,1,1,32'h0,4'd5));
        for (int k = 6; k < 10; k++)
            vecs.push_back(mk(0,0,1,32'(k),0, 0,1,1,32'h0,4'd6));
        // Drain without bubbles.
        vecs.push_back(mk(0,0,0,32'h0,1, 0,1,1,32'd0,4'd6));
        vecs.push_back(mk(0,0,0,32'h0,1, 1,1,1,32'd1,4'd5));
        vecs.push_back(mk(0,0,0,32'h0,1, 1,1,1,32'd2,4'd4));
        vecs.push_back(mk(0,0,0,32'h0,1, 1,1,1,32'd3,4'd3));
        vecs.push_back(mk(0,0,0,32'h0,1, 1,1,1,32'd4,4'd2));
        vecs.push_back(mk(0,0,0,32'h0,1, 1,1,1,32'd5,4'd1));
        vecs.push_back(mk(0,0,0,32'h0,1, 1,0,0,32'h0,4'd0));
        // Flush with a read in flight at level 5; push in the flush cycle is dropped.
        vecs.push_back(mk(0,0,1,32'h10,0, 1,0,0,32'h0,4'd0));
        vecs.push_back(mk(0,0,1,32'h11,0, 1,0,0,32'h0,4'd1));
        vecs.push_back(mk(0,0,1,32'h12,0, 1,0,0,32'h0,4'd2));
        vecs.push_back(mk(0,0,1,32'h13,0, 1,1,1,32'h10,4'd3));
        vecs.push_back(mk(0,0,1,32'h14,0, 1,1,1,32'h10,4'd4));
        vecs.push_back(mk(0,0,1,32'h15,1, 1,1,1,32'h10,4'd5));
        vecs.push_back(mk(0,1,1,32'hEE,0, 1,1,1,32'h11,4'd5));
        vecs.push_back(mk(0,0,0,32'h0,1,  1,0,1,32'h0,4'd0));
        vecs.push_back(mk(0,0,1,32'h77,1, 1,0,0,32'h0,4'd0));
        vecs.push_back(mk(0,0,0,32'h0,1,  1,0,0,32'h0,4'd1));
        vecs.push_back(mk(0,0,0,32'h0,1,  1,0,0,32'h0,4'd1));
        vecs.push_back(mk(0,0,0,32'h0,1,  1,1,1,32'h77,4'd1));
        vecs.push_back(mk(0,0,0,32'h0,1,  1,0,0,32'h0,4'd0));
        vecs.push_back(mk(0,0,0,32'h0,1,  1,0,0,32'h0,4'd0));
        // Reset mid-stream while out_valid_o=1.
        vecs.push_back(mk(0,0,1,32'h31,0, 1,0,0,32'h0,4'd0));
        vecs.push_back(mk(0,0,1,32'h32,0, 1,0,0,32'h0,4'd1));
        vecs.push_back(mk(0,0,0,32'h0,0,  1,0,0,32'h0,4'd2));
        vecs.push_back(mk(1,0,0,32'h0,0,  1,1,1,32'h31,4'd2));
        vecs.push_back(mk(0,0,0,32'h0,1,  1,0,1,32'h0,4'd0));
        vecs.push_back(mk(0,0,0,32'h0,1,  1,0,1,32'h0,4'd0));
    endtask

    task automatic run_table(input int u);
        foreach (vecs[i]) begin
            @(posedge clk); #1;
            rst[u] = vecs[i].r; flush[u] = vecs[i].f; in_valid[u] = vecs[i].iv;
            in_data[u] = vecs[i].id; out_ready[u] = vecs[i].ordy;
            @(negedge clk);
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready[u]), 32'(vecs[i].e_ir));
            check($sformatf("vec%0d_out_valid", i), 32'(out_valid[u]), 32'(vecs[i].e_ov));
            check($sformatf("vec%0d_level", i), 32'(level[u]), 32'(vecs[i].e_lvl));
            if (vecs[i].chk_od)
                check($sformatf("vec%0d_out_data", i), out_data[u], vecs[i].e_od);
        end
    endtask

    // 100 words through the queue; expected data is the arrival order 0..99.
    task automatic run_stream(input int u, input bit rand_ready);
        int sent = 0;
        int got  = 0;
        int cyc  = 0;
        int first_ov = -1;
        while (got < 100 && cyc < 3000) begin
            @(posedge clk); #1;
            rst[u] = 1'b0; flush[u] = 1'b0;
            in_valid[u]  = (sent < 100);
            in_data[u]   = 32'(sent) + (rand_ready ? 32'h1000 : 32'h0);
            out_ready[u] = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            check("stream_level", 32'(level[u]), 32'(sent - got));
            if (out_valid[u] && first_ov < 0) first_ov = cyc;
            if (in_valid[u] && in_ready[u]) sent++;
            if (out_valid[u] && out_ready[u]) begin
                check("stream_data", out_data[u], 32'(got) + (rand_ready ? 32'h1000 : 32'h0));
                got++;
            end
            cyc++;
        end
        check("stream_complete", 32'(got), 32'd100);
        if (!rand_ready) begin
            check("stream_first_valid_cycle", 32'(first_ov), 32'd3);
            check("stream_cycles", 32'(cyc), 32'd103);
        end
        @(posedge clk); #1;
        in_valid[u] = 1'b0;
        out_ready[u] = 1'b0;
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; flush[u] = 1'b0; in_valid[u] = 1'b0;
            in_data[u] = '0; out_ready[u] = 1'b0;
        end
        build_table();
        for (int u = 0; u < 2; u++) begin
            cur_u = u;
            @(posedge clk); #1; rst[u] = 1'b1;
            @(posedge clk); #1; rst[u] = 1'b1;
            run_table(u);
            run_stream(u, 1'b0);
            run_stream(u, 1'b1);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
